// File: rtl/translator_pkg.sv
// Shared translator types: page-number defaults, TLB FSM states and a
// onehot-to-index helper used by the TLB match logic.
package translator_pkg;
  localparam int DCP_PADDR         = 40;
  localparam int TLB_PAGE_OFFSET_W = 12;
  localparam int TLB_ENTRIES       = 8;
  localparam int OH_MAX            = 64;

  typedef logic [DCP_PADDR-TLB_PAGE_OFFSET_W-1:0] pn_t;

  typedef enum logic [1:0] {
    TLB_IDLE,
    TLB_PTW_REQ,
    TLB_PTW_WAIT,
    TLB_RESP
  } tlb_state_e;

  // OR of set-bit positions; exact for onehot inputs, callers truncate to IDX_W.
  function automatic logic [5:0] oh_to_idx(input logic [OH_MAX-1:0] oh);
    logic [5:0] idx;
    idx = '0;
    for (int i = 0; i < OH_MAX; i++)
      if (oh[i]) idx = idx | 6'(i);
    return idx;
  endfunction
endpackage

// File: rtl/cohort_tlb_victim.sv
// Victim picker: lowest free entry, otherwise the round-robin slot.
module cohort_tlb_victim
  import translator_pkg::*;
#(
  parameter  int ENTRIES = TLB_ENTRIES,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic [ENTRIES-1:0] valid,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   victim_idx,
  output logic               all_valid
);
  logic [IDX_W-1:0] free_idx;

  always_comb begin
    free_idx = '0;
    for (int i = ENTRIES-1; i >= 0; i--)
      if (!valid[i]) free_idx = IDX_W'(i);
    all_valid  = &valid;
    victim_idx = all_valid ? rr_ptr : free_idx;
  end
endmodule

// File: rtl/cohort_tlb.sv
// Fully-associative VPN->PPN cache with a single outstanding page-table walk,
// flush support and non-cached faults.
module cohort_tlb
  import translator_pkg::*;
#(
  parameter  int VADDR_W       = 39,
  parameter  int PADDR_W       = DCP_PADDR,
  parameter  int PAGE_OFFSET_W = TLB_PAGE_OFFSET_W,
  parameter  int ENTRIES       = TLB_ENTRIES,
  localparam int VPN_W         = VADDR_W - PAGE_OFFSET_W,
  localparam int PPN_W         = PADDR_W - PAGE_OFFSET_W,
  localparam int IDX_W         = $clog2(ENTRIES)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             lookup_valid_i,
  output logic             lookup_ready_o,
  input  logic [VPN_W-1:0] lookup_vpn_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [PPN_W-1:0] resp_ppn_o,
  output logic             resp_fault_o,
  output logic             ptw_req_valid_o,
  input  logic             ptw_req_ready_i,
  output logic [VPN_W-1:0] ptw_req_vpn_o,
  input  logic             ptw_resp_valid_i,
  input  logic [PPN_W-1:0] ptw_resp_ppn_i,
  input  logic             ptw_resp_fault_i
);
  tlb_state_e                     state_q;
  logic [ENTRIES-1:0]             ent_vld;
  logic [ENTRIES-1:0][VPN_W-1:0]  ent_vpn;
  logic [ENTRIES-1:0][PPN_W-1:0]  ent_ppn;
  logic [IDX_W-1:0]               rr_q;
  logic [VPN_W-1:0]               vpn_q;
  logic [PPN_W-1:0]               ppn_q;
  logic                           fault_q;
  logic                           flushed_q;

  logic [ENTRIES-1:0] hit_vec, dup_vec;
  logic [IDX_W-1:0]   hit_idx, dup_idx, victim_idx, fill_idx;
  logic               all_valid, any_dup, fill, accept;

  // Lookup compares the live request VPN; fill compares the walked VPN.
  for (genvar g = 0; g < ENTRIES; g++) begin : g_cmp
    assign hit_vec[g] = ent_vld[g] && (ent_vpn[g] == lookup_vpn_i);
    assign dup_vec[g] = ent_vld[g] && (ent_vpn[g] == vpn_q);
  end

  assign hit_idx = IDX_W'(oh_to_idx(OH_MAX'(hit_vec)));
  assign dup_idx = IDX_W'(oh_to_idx(OH_MAX'(dup_vec)));
  assign any_dup = |dup_vec;

  cohort_tlb_victim #(.ENTRIES(ENTRIES)) u_victim (
    .valid      (ent_vld),
    .rr_ptr     (rr_q),
    .victim_idx (victim_idx),
    .all_valid  (all_valid)
  );

  assign fill_idx = any_dup ? dup_idx : victim_idx;
  // Flush in this cycle or earlier in the walk suppresses the install.
  assign fill = (state_q == TLB_PTW_WAIT) && ptw_resp_valid_i && !ptw_resp_fault_i
                && !flushed_q && !flush_i;

  assign lookup_ready_o  = (state_q == TLB_IDLE) && !flush_i && !rst_i;
  assign accept          = lookup_valid_i && lookup_ready_o;
  assign resp_valid_o    = (state_q == TLB_RESP);
  assign resp_ppn_o      = ppn_q;
  assign resp_fault_o    = fault_q;
  assign ptw_req_valid_o = (state_q == TLB_PTW_REQ);
  assign ptw_req_vpn_o   = vpn_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= TLB_IDLE;
      ent_vld   <= '0;
      rr_q      <= '0;
      vpn_q     <= '0;
      ppn_q     <= '0;
      fault_q   <= 1'b0;
      flushed_q <= 1'b0;
    end else begin
      if (flush_i)   ent_vld <= '0;
      else if (fill) ent_vld[fill_idx] <= 1'b1;
      if (fill && !any_dup && all_valid) rr_q <= rr_q + 1'b1;

      case (state_q)
        TLB_IDLE: if (accept) begin
          vpn_q     <= lookup_vpn_i;
          flushed_q <= 1'b0;
          if (|hit_vec) begin
            ppn_q   <= ent_ppn[hit_idx];
            fault_q <= 1'b0;
            state_q <= TLB_RESP;
          end else begin
            state_q <= TLB_PTW_REQ;
          end
        end
        TLB_PTW_REQ: begin
          if (flush_i) flushed_q <= 1'b1;
          if (ptw_req_ready_i) state_q <= TLB_PTW_WAIT;
        end
        TLB_PTW_WAIT: begin
          if (flush_i) flushed_q <= 1'b1;
          if (ptw_resp_valid_i) begin
            ppn_q   <= ptw_resp_ppn_i;
            fault_q <= ptw_resp_fault_i;
            state_q <= TLB_RESP;
          end
        end
        TLB_RESP: if (resp_ready_i) state_q <= TLB_IDLE;
        default:  state_q <= TLB_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (fill) begin
      ent_vpn[fill_idx] <= vpn_q;
      ent_ppn[fill_idx] <= ptw_resp_ppn_i;
    end
  end

  a_onehot_hit: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(hit_vec));
  a_onehot_dup: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(dup_vec));
  a_ptw_resp:   assert property (@(posedge clk_i) disable iff (rst_i)
                                 ptw_resp_valid_i |-> state_q == TLB_PTW_WAIT);
endmodule

// File: doc/cohort_tlb.md
Name: cohort_tlb

Overview:
- Parametrised fully-associative page-number translation cache for the Cohort translator path.
- Maps virtual page numbers (VPNs) to physical page numbers (PPNs) for one requester.
- On a miss it issues one request to the page-table walker (PTW) and installs the returned PPN.
- Generalises the fixed 12-bit-offset page number type to configurable address, offset and entry widths, and adds flush and fault handling.

Parameters:
- VADDR_W, 39, virtual address width.
- PADDR_W, 40, physical address width (matches DCP_PADDR default).
- PAGE_OFFSET_W, 12, page offset bits. VPN_W = VADDR_W-PAGE_OFFSET_W; PPN_W = PADDR_W-PAGE_OFFSET_W.
- ENTRIES, 8, number of TLB entries. Must be ≥2 and a power of two. IDX_W = $clog2(ENTRIES).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- flush_i  in  1  invalidate all entries
- lookup_valid_i  in  1  translation request valid
- lookup_ready_o  out  1  request accepted when valid&ready
- lookup_vpn_i  in  VPN_W  VPN to translate
- resp_valid_o  out  1  translation result valid
- resp_ready_i  in  1  requester accepts result
- resp_ppn_o  out  PPN_W  translated PPN
- resp_fault_o  out  1  translation faulted
- ptw_req_valid_o  out  1  walk request valid
- ptw_req_ready_i  in  1  walker accepts request
- ptw_req_vpn_o  out  VPN_W  VPN to walk
- ptw_resp_valid_i  in  1  walk result valid, single-cycle pulse
- ptw_resp_ppn_i  in  PPN_W  walked PPN
- ptw_resp_fault_i  in  1  walk faulted

Behaviour:
- Reset values (asynchronous, rst_i high):
  - all entry valid bits 0; round-robin pointer 0; state IDLE.
  - resp_valid_o=0, resp_ppn_o=0, resp_fault_o=0.
  - ptw_req_valid_o=0, ptw_req_vpn_o=0.
  - lookup_ready_o=0 during reset, 1 once in IDLE.
- States: IDLE, PTW_REQ, PTW_WAIT, RESP.
- IDLE:
  - lookup_ready_o = !flush_i.
  - On accept, the VPN is compared against all valid entries combinationally and the VPN is registered.
  - Hit: the matching PPN is registered, fault=0, next state RESP. Hit latency is 1 cycle (resp_valid_o high the cycle after accept).
  - Miss: next state PTW_REQ.
- PTW_REQ:
  - ptw_req_valid_o=1, ptw_req_vpn_o = the registered VPN.
  - Held stable until ptw_req_ready_i, then PTW_WAIT.
- PTW_WAIT:
  - On ptw_resp_valid_i, the PPN and fault are registered to the response, next state RESP.
  - If !ptw_resp_fault_i, the entry is filled in the same cycle. Faults are never cached.
- RESP:
  - resp_valid_o=1; data is held stable until resp_ready_i, then IDLE.
  - lookup_ready_o=0 in every state except IDLE, so there is at most one outstanding translation.
- Victim selection: the lowest-index invalid entry. If all entries are valid, the entry at the round-robin pointer is replaced and the pointer increments mod ENTRIES. The pointer increments only on fills into a full TLB.
- Duplicate prevention: a fill whose VPN already matches a valid entry (possible only after races) overwrites that entry instead of allocating a new one.
- Multiple matches are impossible by construction. An assertion flags onehot0 violation.
- Flush rules:
  - Flush clears all valid bits in one cycle and does not reset the round-robin pointer.
  - Flush in IDLE blocks accept that cycle.
  - Flush in PTW_REQ or PTW_WAIT lets the walk complete and the response is delivered to the requester, but the fill is suppressed: a sticky "flushed" flag set in that translation suppresses the install.
  - Flush in RESP does not alter the held response.
  - Flush coincident with a fill cycle: flush wins and the entry is not installed.
- Unexpected input: ptw_resp_valid_i outside PTW_WAIT is ignored and flagged by assertion.

Decomposition:
- translator_pkg gains:
  - default constants TLB_PAGE_OFFSET_W=12 and TLB_ENTRIES=8;
  - a state enum tlb_state_e;
  - a function for onehot-to-index.
- pn_t stays as the DCP_PADDR-based default.
- Entry storage is parametrised by VPN_W/PPN_W inside the module.
- One sub-module, cohort_tlb_victim: purely combinational. Inputs are the valid vector and round-robin pointer; outputs are the victim index and an all-valid flag.

Test Plan:
- Cold miss: lookup VPN 0x12345 after reset, PTW ready immediately, response PPN 0xABCDE two cycles later. Required: ptw_req_vpn_o=0x12345; resp_ppn_o=0xABCDE, fault=0; entry 0 valid.
- Hit: repeat lookup of 0x12345. Required: resp_valid_o high exactly 1 cycle after accept with PPN 0xABCDE and no PTW request.
- Fault: lookup 0x00777, walk returns fault=1. Required: resp_fault_o=1; a re-lookup of 0x00777 issues a new PTW request (not cached).
- Replacement: fill VPNs 0–7 (ENTRIES=8), then VPNs 8 and 9. Required: entry 0 holds VPN 8 and entry 1 holds VPN 9 (round-robin); lookup of VPN 0 misses and VPN 2 hits.
- Flush mid-walk: assert flush_i during PTW_WAIT. Required: response still delivered with the returned PPN; a subsequent lookup of the same VPN misses; every earlier entry also misses.
- Backpressure: hold resp_ready_i=0 for 5 cycles, stall ptw_req_ready_i for 3 cycles. Required: ptw_req_valid_o/vpn and resp outputs stable, lookup_ready_o=0 throughout; assert rst_i mid-RESP and require all outputs at reset values in the same cycle.
